// File: rtl/mult_batch_sequencer_if.sv
// Bundle of control, register-file read and RAM write signals for the batch
// multiply sequencer. The master side is the top-level control that owns the
// register file and RAM; the slave side is the sequencer itself.
interface mult_batch_sequencer_if #(
  parameter int DATA_W    = 4,
  parameter int RF_ADR_W  = 3,
  parameter int RAM_ADR_W = 4
);

  // Batch request and parameters
  logic                   start;
  logic                   abort;
  logic [RF_ADR_W-1:0]    base_a;
  logic [RF_ADR_W-1:0]    base_b;
  logic [RAM_ADR_W-1:0]   ram_base;
  logic [RF_ADR_W:0]      count;

  // Register-file read ports (data is combinational from the address)
  logic [RF_ADR_W-1:0]    rf_adr_a;
  logic [RF_ADR_W-1:0]    rf_adr_b;
  logic [DATA_W-1:0]      rf_rdata_a;
  logic [DATA_W-1:0]      rf_rdata_b;

  // RAM write port
  logic                   ram_we;
  logic [RAM_ADR_W-1:0]   ram_addr;
  logic [2*DATA_W-1:0]    ram_wdata;

  // Status
  logic                   busy;
  logic                   done;
  logic [3:0]             st_out;

  modport master (
    output start, abort, base_a, base_b, ram_base, count,
    output rf_rdata_a, rf_rdata_b,
    input  rf_adr_a, rf_adr_b,
    input  ram_we, ram_addr, ram_wdata,
    input  busy, done, st_out
  );

  modport slave (
    input  start, abort, base_a, base_b, ram_base, count,
    input  rf_rdata_a, rf_rdata_b,
    output rf_adr_a, rf_adr_b,
    output ram_we, ram_addr, ram_wdata,
    output busy, done, st_out
  );

endinterface

// File: rtl/mult_batch_sequencer.sv
// Batch controller for the register-file / multiplier / RAM datapath.
// One accepted start runs `count` jobs; job i multiplies rf[base_a+i] by
// rf[base_b+i] and writes the full-width product to ram[ram_base+i].
// Every job takes four cycles (FETCH, MUL, WRITE, NEXT) and a batch ends
// with a single DONE cycle. All outputs are registers loaded from the
// next-state value, so they present the Moore decode of the current state
// while never glitching.
module mult_batch_sequencer #(
  parameter int DATA_W    = 4,
  parameter int RF_ADR_W  = 3,
  parameter int RAM_ADR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  mult_batch_sequencer_if.slave   bus
);

  localparam int PROD_W = 2 * DATA_W;

  // State codes are visible on st_out, so they are fixed values.
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FETCH = 4'd1;
  localparam logic [3:0] ST_MUL   = 4'd2;
  localparam logic [3:0] ST_WRITE = 4'd3;
  localparam logic [3:0] ST_NEXT  = 4'd4;
  localparam logic [3:0] ST_DONE  = 4'd5;

  localparam logic [RF_ADR_W:0]    CNT_ZERO  = {(RF_ADR_W+1){1'b0}};
  localparam logic [RF_ADR_W:0]    CNT_ONE   = {{RF_ADR_W{1'b0}}, 1'b1};
  localparam logic [RF_ADR_W-1:0]  IDX_ZERO  = {RF_ADR_W{1'b0}};
  localparam logic [RF_ADR_W-1:0]  IDX_ONE   = {{(RF_ADR_W-1){1'b0}}, 1'b1};
  localparam logic [RAM_ADR_W-1:0] RAM_ZERO  = {RAM_ADR_W{1'b0}};
  localparam logic [DATA_W-1:0]    DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [PROD_W-1:0]    PROD_ZERO = {PROD_W{1'b0}};

  // Register-file address of a job: base plus index, wrapping silently.
  function automatic logic [RF_ADR_W-1:0] rf_job_addr(
    input logic [RF_ADR_W-1:0] base,
    input logic [RF_ADR_W-1:0] idx
  );
    return base + idx;
  endfunction

  // RAM address of a job: base plus zero-extended index, wrapping silently.
  function automatic logic [RAM_ADR_W-1:0] ram_job_addr(
    input logic [RAM_ADR_W-1:0] base,
    input logic [RF_ADR_W-1:0]  idx
  );
    return base + RAM_ADR_W'(idx);
  endfunction

  // Unsigned full-width product, no truncation.
  function automatic logic [PROD_W-1:0] full_product(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return PROD_W'(a) * PROD_W'(b);
  endfunction

  // FSM and batch bookkeeping
  logic [3:0]            state_r;
  logic [3:0]            state_nxt_s;
  logic [RF_ADR_W-1:0]   base_a_r;
  logic [RF_ADR_W-1:0]   base_b_r;
  logic [RAM_ADR_W-1:0]  ram_base_r;
  logic [RF_ADR_W:0]     count_r;
  logic [RF_ADR_W-1:0]   idx_r;
  logic [RF_ADR_W-1:0]   idx_inc_s;
  logic                  accept_s;
  logic                  last_job_s;
  logic                  advance_s;

  // Datapath registers
  logic [DATA_W-1:0]     op_a_r;
  logic [DATA_W-1:0]     op_b_r;
  logic [PROD_W-1:0]     product_r;

  // Output registers
  logic [RF_ADR_W-1:0]   rf_adr_a_r;
  logic [RF_ADR_W-1:0]   rf_adr_b_r;
  logic                  ram_we_r;
  logic [RAM_ADR_W-1:0]  ram_addr_r;
  logic                  busy_r;
  logic                  done_r;
  logic [3:0]            st_out_r;

  // A start is taken only in IDLE, and an abort in the same cycle cancels it.
  always_comb begin
    accept_s   = (state_r == ST_IDLE) && bus.start && !bus.abort;
    last_job_s = ({1'b0, idx_r} == (count_r - CNT_ONE));
    idx_inc_s  = idx_r + IDX_ONE;
    advance_s  = (state_r == ST_NEXT) && !bus.abort && !last_job_s;
  end

  // Next-state decode; abort from any busy state returns to IDLE.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.count == CNT_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_MUL: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (last_job_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the batch parameters once per accepted start; later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_a_r   <= IDX_ZERO;
      base_b_r   <= IDX_ZERO;
      ram_base_r <= RAM_ZERO;
      count_r    <= CNT_ZERO;
    end else if (accept_s) begin
      base_a_r   <= bus.base_a;
      base_b_r   <= bus.base_b;
      ram_base_r <= bus.ram_base;
      count_r    <= bus.count;
    end else begin
      base_a_r   <= base_a_r;
      base_b_r   <= base_b_r;
      ram_base_r <= ram_base_r;
      count_r    <= count_r;
    end
  end

  // Job index: cleared on start, stepped when NEXT loops back to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r <= IDX_ZERO;
    end else if (accept_s) begin
      idx_r <= IDX_ZERO;
    end else if (advance_s) begin
      idx_r <= idx_inc_s;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Capture both register-file operands while their addresses are presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_r <= DATA_ZERO;
      op_b_r <= DATA_ZERO;
    end else if (state_r == ST_FETCH) begin
      op_a_r <= bus.rf_rdata_a;
      op_b_r <= bus.rf_rdata_b;
    end else begin
      op_a_r <= op_a_r;
      op_b_r <= op_b_r;
    end
  end

  // Status outputs follow the state being entered so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ram_we_r <= 1'b0;
      st_out_r <= ST_IDLE;
    end else begin
      busy_r   <= (state_nxt_s != ST_IDLE);
      done_r   <= (state_nxt_s == ST_DONE);
      ram_we_r <= (state_nxt_s == ST_WRITE);
      st_out_r <= state_nxt_s;
    end
  end

  // RF read addresses: loaded on entry to FETCH, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_adr_a_r <= IDX_ZERO;
      rf_adr_b_r <= IDX_ZERO;
    end else if ((state_nxt_s == ST_FETCH) && (state_r == ST_IDLE)) begin
      // First job of a batch: index is zero, use the incoming bases directly.
      rf_adr_a_r <= bus.base_a;
      rf_adr_b_r <= bus.base_b;
    end else if (state_nxt_s == ST_FETCH) begin
      rf_adr_a_r <= rf_job_addr(base_a_r, idx_inc_s);
      rf_adr_b_r <= rf_job_addr(base_b_r, idx_inc_s);
    end else begin
      rf_adr_a_r <= rf_adr_a_r;
      rf_adr_b_r <= rf_adr_b_r;
    end
  end

  // MUL stage: product and RAM address are loaded as WRITE is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr_r <= RAM_ZERO;
      product_r  <= PROD_ZERO;
    end else if (state_nxt_s == ST_WRITE) begin
      ram_addr_r <= ram_job_addr(ram_base_r, idx_r);
      product_r  <= full_product(op_a_r, op_b_r);
    end else begin
      ram_addr_r <= ram_addr_r;
      product_r  <= product_r;
    end
  end

  assign bus.rf_adr_a  = rf_adr_a_r;
  assign bus.rf_adr_b  = rf_adr_b_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = product_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.st_out    = st_out_r;

endmodule
